// File: rtl/sram_like_responder.sv
// Single-outstanding SRAM-like responder with separate instruction and data ports.
// Data requests take priority; each accepted request completes with one data_ok after LATENCY cycles.
module sram_like_responder #(
    parameter int ADDR_WIDTH = 14,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [3:0] LOAD = 4'(LATENCY - 1);

    state_t                  state_r;
    state_t                  state_s;
    logic [3:0]              cnt_r;
    logic [3:0]              cnt_s;
    logic                    port_r;       // 1'b1 = data port owns the transaction
    logic                    port_s;
    logic [31:0]             word_r;
    logic [31:0]             mem_r [0:(1 << ADDR_WIDTH) - 1];

    logic                    hs_s;
    logic                    hs_data_s;
    logic                    hs_wr_s;
    logic [ADDR_WIDTH-1:0]   hs_idx_s;
    logic [31:0]             hs_wdata_s;
    logic [3:0]              hs_wstrb_s;
    logic                    done_s;

    // Byte offset, size and out-of-range address bits never affect the access.
    logic unused_s;
    assign unused_s = ^{inst_sram_size, data_sram_size,
                        inst_sram_addr[31:ADDR_WIDTH+2], inst_sram_addr[1:0],
                        data_sram_addr[31:ADDR_WIDTH+2], data_sram_addr[1:0]};

    // Arbitration, handshake mux, next-state logic and response outputs.
    always_comb begin
        state_s           = state_r;
        cnt_s             = cnt_r;
        port_s            = port_r;
        data_sram_addr_ok = 1'b0;
        inst_sram_addr_ok = 1'b0;
        if (!reset && (state_r == IDLE)) begin
            data_sram_addr_ok = data_sram_req;
            inst_sram_addr_ok = inst_sram_req & ~data_sram_req;
        end else begin
            data_sram_addr_ok = 1'b0;
            inst_sram_addr_ok = 1'b0;
        end

        hs_data_s = data_sram_addr_ok;
        hs_s      = data_sram_addr_ok | inst_sram_addr_ok;
        if (hs_data_s) begin
            hs_wr_s    = data_sram_wr;
            hs_idx_s   = data_sram_addr[ADDR_WIDTH+1:2];
            hs_wdata_s = data_sram_wdata;
            hs_wstrb_s = data_sram_wstrb;
        end else begin
            hs_wr_s    = inst_sram_wr;
            hs_idx_s   = inst_sram_addr[ADDR_WIDTH+1:2];
            hs_wdata_s = inst_sram_wdata;
            hs_wstrb_s = inst_sram_wstrb;
        end

        case (state_r)
            IDLE: begin
                if (hs_s) begin
                    state_s = BUSY;
                    cnt_s   = LOAD;
                    port_s  = hs_data_s;
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                if (cnt_r == 4'd0) begin
                    state_s = IDLE;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = 4'd0;
            end
        endcase

        done_s            = !reset && (state_r == BUSY) && (cnt_r == 4'd0);
        data_sram_data_ok = done_s & port_r;
        inst_sram_data_ok = done_s & ~port_r;
        data_sram_rdata   = data_sram_data_ok ? word_r : 32'h0000_0000;
        inst_sram_rdata   = inst_sram_data_ok ? word_r : 32'h0000_0000;
    end

    // Control state; the response word is 0 for writes so rdata needs no extra mux.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
            port_r  <= 1'b1;
            word_r  <= 32'h0000_0000;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            port_r  <= port_s;
            if (hs_s) begin
                word_r <= hs_wr_s ? 32'h0000_0000 : mem_r[hs_idx_s];
            end else begin
                word_r <= word_r;
            end
        end
    end

    // Storage array: byte-strobed writes at the handshake edge, never cleared by reset.
    always_ff @(posedge clk) begin
        if (hs_s && hs_wr_s) begin
            for (int k = 0; k < 4; k++) begin
                if (hs_wstrb_s[k]) begin
                    mem_r[hs_idx_s][8*k +: 8] <= hs_wdata_s[8*k +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_like_responder.sv
// Directed bench for sram_like_responder: five instances cover LATENCY 1, 2, 3, 4 and 15.
module tb_sram_like_responder;

    logic        clk;
    logic        rst     [5];
    logic        i_req   [5];
    logic        i_wr    [5];
    logic [1:0]  i_size  [5];
    logic [3:0]  i_wstrb [5];
    logic [31:0] i_addr  [5];
    logic [31:0] i_wdata [5];
    logic        i_aok   [5];
    logic        i_dok   [5];
    logic [31:0] i_rdata [5];
    logic        d_req   [5];
    logic        d_wr    [5];
    logic [1:0]  d_size  [5];
    logic [3:0]  d_wstrb [5];
    logic [31:0] d_addr  [5];
    logic [31:0] d_wdata [5];
    logic        d_aok   [5];
    logic        d_dok   [5];
    logic [31:0] d_rdata [5];

    int n_cmp = 0;
    int n_err = 0;

    for (genvar g = 0; g < 5; g++) begin : g_dut
        localparam int L = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 3 : (g == 3) ? 4 : 15;
        sram_like_responder #(.ADDR_WIDTH(14), .LATENCY(L)) dut (
            .clk               (clk),
            .reset             (rst[g]),
            .inst_sram_req     (i_req[g]),
            .inst_sram_wr      (i_wr[g]),
            .inst_sram_size    (i_size[g]),
            .inst_sram_wstrb   (i_wstrb[g]),
            .inst_sram_addr    (i_addr[g]),
            .inst_sram_wdata   (i_wdata[g]),
            .inst_sram_addr_ok (i_aok[g]),
            .inst_sram_data_ok (i_dok[g]),
            .inst_sram_rdata   (i_rdata[g]),
            .data_sram_req     (d_req[g]),
            .data_sram_wr      (d_wr[g]),
            .data_sram_size    (d_size[g]),
            .data_sram_wstrb   (d_wstrb[g]),
            .data_sram_addr    (d_addr[g]),
            .data_sram_wdata   (d_wdata[g]),
            .data_sram_addr_ok (d_aok[g]),
            .data_sram_data_ok (d_dok[g]),
            .data_sram_rdata   (d_rdata[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat_of(input int k);
        case (k)
            0: return 1;
            1: return 2;
            2: return 3;
            3: return 4;
            default: return 15;
        endcase
    endfunction

    function automatic logic aok(input int k, input bit dp);
        return dp ? d_aok[k] : i_aok[k];
    endfunction

    function automatic logic dok(input int k, input bit dp);
        return dp ? d_dok[k] : i_dok[k];
    endfunction

    function automatic logic [31:0] rdat(input int k, input bit dp);
        return dp ? d_rdata[k] : i_rdata[k];
    endfunction

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s (dut %0d): observed %h expected %h", tag, k, obs, exp);
        end
    endtask

    task automatic drive(input int k, input bit dp, input logic req, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] ws);
        if (dp) begin
            d_req[k] = req; d_wr[k] = wr; d_addr[k] = addr; d_wdata[k] = wd; d_wstrb[k] = ws;
        end else begin
            i_req[k] = req; i_wr[k] = wr; i_addr[k] = addr; i_wdata[k] = wd; i_wstrb[k] = ws;
        end
    endtask

    // One transaction; req stays high through BUSY to show it is ignored there.
    task automatic xfer(input int k, input bit dp, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] ws, input logic [31:0] exp);
        int lat;
        lat = lat_of(k);
        @(negedge clk);
        drive(k, dp, 1'b1, wr, addr, wd, ws);
        #1;
        chk("hs_addr_ok", k, 32'(aok(k, dp)), 32'd1);
        chk("hs_other_addr_ok", k, 32'(aok(k, !dp)), 32'd0);
        chk("hs_data_ok", k, 32'(dok(k, dp)), 32'd0);
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            #1;
            chk("busy_addr_ok", k, {30'd0, d_aok[k], i_aok[k]}, 32'd0);
            chk("data_ok", k, 32'(dok(k, dp)), 32'(c == lat));
            chk("rdata", k, rdat(k, dp), (c == lat) ? exp : 32'h0000_0000);
        end
        drive(k, dp, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 4'b0000);
    endtask

    initial begin
        for (int k = 0; k < 5; k++) begin
            rst[k] = 1'b1;
            i_size[k] = 2'b10;
            d_size[k] = 2'b10;
            drive(k, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 4'b0000);
            drive(k, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 4'b0000);
        end

        // Outputs stay low under reset even with both requests raised.
        @(negedge clk);
        d_req[1] = 1'b1;
        i_req[1] = 1'b1;
        #1;
        chk("rst_d_addr_ok", 1, 32'(d_aok[1]), 32'd0);
        chk("rst_i_addr_ok", 1, 32'(i_aok[1]), 32'd0);
        chk("rst_d_data_ok", 1, 32'(d_dok[1]), 32'd0);
        chk("rst_d_rdata", 1, d_rdata[1], 32'h0000_0000);
        @(negedge clk);
        d_req[1] = 1'b0;
        i_req[1] = 1'b0;
        for (int k = 0; k < 5; k++) rst[k] = 1'b0;

        // Basic write/read, byte strobes, wrap-around, inst port, zero-strobe write.
        xfer(1, 1'b1, 1'b1, 32'h0000_0010, 32'h1122_3344, 4'b1111, 32'h0000_0000);
        xfer(1, 1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 4'b0000, 32'h1122_3344);
        xfer(1, 1'b1, 1'b1, 32'h0000_0010, 32'hAABB_CCDD, 4'b0101, 32'h0000_0000);
        xfer(1, 1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 4'b0000, 32'h11BB_33DD);
        xfer(1, 1'b1, 1'b1, 32'h0001_0004, 32'hDEAD_BEEF, 4'b1111, 32'h0000_0000);
        xfer(1, 1'b0, 1'b0, 32'h0000_0004, 32'h0000_0000, 4'b0000, 32'hDEAD_BEEF);
        xfer(1, 1'b0, 1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'b0000, 32'h0000_0000);
        xfer(1, 1'b1, 1'b0, 32'h0000_0012, 32'h0000_0000, 4'b0000, 32'h11BB_33DD);

        // Memory survives a reset pulse.
        @(negedge clk);
        rst[1] = 1'b1;
        @(negedge clk);
        rst[1] = 1'b0;
        xfer(1, 1'b0, 1'b0, 32'h0000_0010, 32'h0000_0000, 4'b0000, 32'h11BB_33DD);

        // Arbitration with LATENCY=1: both ports request from cycle 0.
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 1'b1, 32'h0000_0040, 32'h0000_0001, 4'b1111);
        drive(0, 1'b0, 1'b1, 1'b1, 32'h0000_0044, 32'h0000_0002, 4'b0000);
        #1;
        chk("arb_c0_d_addr_ok", 0, 32'(d_aok[0]), 32'd1);
        chk("arb_c0_i_addr_ok", 0, 32'(i_aok[0]), 32'd0);
        @(negedge clk);
        #1;
        chk("arb_c1_d_data_ok", 0, 32'(d_dok[0]), 32'd1);
        chk("arb_c1_d_rdata", 0, d_rdata[0], 32'h0000_0000);
        chk("arb_c1_addr_ok", 0, {30'd0, d_aok[0], i_aok[0]}, 32'd0);
        d_req[0] = 1'b0;
        @(negedge clk);
        #1;
        chk("arb_c2_i_addr_ok", 0, 32'(i_aok[0]), 32'd1);
        chk("arb_c2_d_addr_ok", 0, 32'(d_aok[0]), 32'd0);
        chk("arb_c2_i_data_ok", 0, 32'(i_dok[0]), 32'd0);
        @(negedge clk);
        #1;
        chk("arb_c3_i_data_ok", 0, 32'(i_dok[0]), 32'd1);
        chk("arb_c3_i_rdata", 0, i_rdata[0], 32'h0000_0000);
        chk("arb_c3_addr_ok", 0, {30'd0, d_aok[0], i_aok[0]}, 32'd0);
        i_req[0] = 1'b0;

        // Latency sweep: 1, 3, 15.
        xfer(0, 1'b1, 1'b1, 32'h0000_0010, 32'h0102_0304, 4'b1111, 32'h0000_0000);
        xfer(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 4'b0000, 32'h0102_0304);
        xfer(2, 1'b1, 1'b1, 32'h0000_0010, 32'h0506_0708, 4'b1111, 32'h0000_0000);
        xfer(2, 1'b0, 1'b0, 32'h0000_0010, 32'h0000_0000, 4'b0000, 32'h0506_0708);
        xfer(4, 1'b1, 1'b1, 32'h0000_0010, 32'h090A_0B0C, 4'b1111, 32'h0000_0000);
        xfer(4, 1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 4'b0000, 32'h090A_0B0C);

        // Reset mid-write with LATENCY=4: write lands, its response is dropped.
        @(negedge clk);
        drive(3, 1'b1, 1'b1, 1'b1, 32'h0000_0020, 32'h5555_5555, 4'b1111);
        #1;
        chk("mid_hs_addr_ok", 3, 32'(d_aok[3]), 32'd1);
        @(negedge clk);
        drive(3, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 4'b0000);
        #1;
        chk("mid_c1_data_ok", 3, 32'(d_dok[3]), 32'd0);
        @(negedge clk);
        rst[3] = 1'b1;
        #1;
        chk("mid_c2_data_ok", 3, 32'(d_dok[3]), 32'd0);
        chk("mid_c2_rdata", 3, d_rdata[3], 32'h0000_0000);
        @(posedge clk);
        #1;
        rst[3] = 1'b0;
        xfer(3, 1'b1, 1'b0, 32'h0000_0020, 32'h0000_0000, 4'b0000, 32'h5555_5555);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sram_like_responder.md
SRAM_LIKE_RESPONDER -- requirements
Module: sram_like_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 14; number of word-index bits, so memory depth is 2^ADDR_WIDTH 32-bit words.
REQ-002 SHALL have parameter LATENCY, default 2; cycles from an accepted request to its data_ok, legal range 1..15.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports inst_sram_req/wr  input  1 each; ports inst_sram_size  input  2; inst_sram_wstrb  input  4; inst_sram_addr  input  32; inst_sram_wdata  input  32. These form the instruction-port request.
REQ-006 SHALL have ports inst_sram_addr_ok, inst_sram_data_ok  output  1 each; inst_sram_rdata  output  32. These form the instruction-port response.
REQ-007 SHALL have ports data_sram_req/wr/size/wstrb/addr/wdata  input, with the same widths as REQ-005. These form the data-port request.
REQ-008 SHALL have ports data_sram_addr_ok, data_sram_data_ok  output  1 each; data_sram_rdata  output  32. These form the data-port response.

Function
REQ-009 SHALL implement a state machine with two states: IDLE and BUSY.
REQ-010 In IDLE, SHALL grant one request per cycle. A pending data request wins; otherwise a pending inst request is granted.
REQ-011 <port>_addr_ok SHALL be combinational: 1 iff state is IDLE, <port>_req is 1, and that port is granted. The two addr_ok outputs SHALL never be 1 in the same cycle.
REQ-012 A handshake (req and addr_ok both 1) SHALL do the following at that edge:
- latch the port id;
- move to BUSY;
- load the latency counter with LATENCY-1.
REQ-013 Word index SHALL be addr[ADDR_WIDTH+1:2]. Higher address bits are ignored, so addresses wrap modulo the memory size. addr[1:0] and size are accepted but do not affect the access.
REQ-014 A write handshake SHALL update, at the handshake edge, exactly the bytes whose wstrb bit is 1. Byte lane k = wdata[8k+7:8k]. wstrb=0000 leaves memory unchanged but still completes.
REQ-015 A read handshake SHALL capture the full addressed word at the handshake edge, before any write in that same edge.
REQ-016 In BUSY, the counter SHALL decrement each cycle while nonzero.
REQ-017 When the counter is 0 in BUSY, the latched port's data_ok SHALL be 1 for exactly one cycle, and the state SHALL return to IDLE at the next edge.
REQ-018 data_ok SHALL therefore rise exactly LATENCY cycles after the handshake cycle.
REQ-019 No addr_ok SHALL be asserted while BUSY, including the data_ok cycle; at most one transaction is outstanding.
REQ-020 Every request SHALL receive a data_ok, including writes.
REQ-021 rdata during data_ok SHALL be the captured word for reads and 32'h0 for writes.
REQ-022 rdata SHALL be 32'h0 whenever the port's data_ok is 0.
REQ-023 Request inputs SHALL be ignored while BUSY. A requester holding req across BUSY is granted in the first IDLE cycle, with data priority reapplied.
REQ-024 Simultaneous inst and data requests SHALL be serviced data first, then inst: inst addr_ok in the cycle after data's data_ok.

Reset
REQ-025 While reset=1, SHALL force state=IDLE, counter=0, and latched port id=data.
REQ-026 While reset=1, SHALL drive all addr_ok, data_ok and rdata outputs to 0 in the same cycle.
REQ-027 Reset during BUSY SHALL discard the pending response, with no data_ok after reset. A write already committed at its handshake SHALL remain in memory.
REQ-028 Memory contents SHALL NOT be cleared by reset.

Verification
REQ-029 Bench with LATENCY=2: data write addr=0x0000_0010, wdata=0x1122_3344, wstrb=1111; then read the same address. Required:
- write data_ok 2 cycles after its handshake, data_rdata=0;
- read data_ok with data_rdata=0x1122_3344.
REQ-030 Byte-strobe check: write 0xAABB_CCDD with wstrb=0101 over 0x1122_3344 at 0x10, then read. Required: rdata=0x11BB_33DD.
REQ-031 Arbitration: inst_req and data_req both held from cycle 0 with LATENCY=1. Required sequence:
- data_addr_ok at cycle 0;
- data_data_ok at cycle 1;
- inst_addr_ok at cycle 2;
- inst_data_ok at cycle 3;
- never both addr_ok high together.
REQ-032 Wrap-around with ADDR_WIDTH=14: write 0xDEAD_BEEF to 0x0001_0004, then read 0x0000_0004. Required: rdata=0xDEAD_BEEF.
REQ-033 Mid-operation reset with LATENCY=4: write 0x5555_5555 to 0x20; assert reset 2 cycles after the handshake, release 1 cycle later. Required:
- no data_ok for that write;
- next request accepted in the first cycle after release;
- read of 0x20 returns 0x5555_5555.
REQ-034 Latency sweep for LATENCY in {1,3,15}: a single read SHALL show data_ok exactly LATENCY cycles after addr_ok, and no addr_ok before that data_ok clears.
